// File: rtl/sr_count_sequencer_if.sv
// Bundle between counter-level control, the SR flip-flop bank and the sequencer.
// master: control logic plus bank (drives commands and q); slave: the sequencer.
interface sr_count_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             dir;
  logic             load_en;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start, stop, dir, load_en, load_val, limit, q,
    input  s, r, busy, tc, done
  );

  modport slave (
    input  start, stop, dir, load_en, load_val, limit, q,
    output s, r, busy, tc, done
  );
endinterface

// File: rtl/sr_count_sequencer.sv
// Sequences a bank of WIDTH SR flip-flops as an up/down counter with
// parallel load, latched limit and terminal-count/done signalling.
// Optional feature macro: SR_SEQ_AUTORELOAD_EN (free-running reload at limit).
module sr_count_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  sr_count_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             dir_q;
  logic [WIDTH-1:0] load_val_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] target;
  logic             drive;
  logic             tc_int;
  logic             done_int;
  logic             at_limit;

  assign at_limit = (bus.q == limit_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Run parameters captured when a run is accepted; ignored afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q      <= 1'b0;
      load_val_q <= '0;
      limit_q    <= '0;
    end else if (state == IDLE && bus.start && !bus.stop) begin
      dir_q      <= bus.dir;
      load_val_q <= bus.load_val;
      limit_q    <= bus.limit;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start && !bus.stop) state_nxt = bus.load_en ? LOAD : RUN;
      LOAD: state_nxt = bus.stop ? IDLE : RUN;
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (at_limit) begin
`ifdef SR_SEQ_AUTORELOAD_EN
          state_nxt = RUN;
`else
          state_nxt = DONE;
`endif
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Target value and status decode; drive=0 means every bit holds
  always_comb begin
    target   = '0;
    drive    = 1'b0;
    tc_int   = 1'b0;
    done_int = 1'b0;
    unique case (state)
      LOAD: begin
        if (!bus.stop) begin
          drive  = 1'b1;
          target = load_val_q;
        end
      end
      RUN: begin
        if (!bus.stop) begin
          if (at_limit) begin
            tc_int = 1'b1;
`ifdef SR_SEQ_AUTORELOAD_EN
            drive  = 1'b1;
            target = load_val_q;
`endif
          end else begin
            drive  = 1'b1;
            target = dir_q ? (bus.q + WIDTH'(1)) : (bus.q - WIDTH'(1));
          end
        end
      end
      DONE:    done_int = 1'b1;
      default: ;
    endcase
  end

  // Excitation: set bits rising toward target, reset bits falling; reset silences the bank
  always_comb begin
    bus.s    = '0;
    bus.r    = '0;
    bus.tc   = 1'b0;
    bus.done = 1'b0;
    bus.busy = (state != IDLE);
    if (!rst) begin
      if (drive) begin
        bus.s = target & ~bus.q;
        bus.r = ~target & bus.q;
      end
      bus.tc   = tc_int;
      bus.done = done_int;
    end
  end

endmodule
